// File: rtl/ccd_blob_tracker_pkg.sv
// Shared widths, FSM encoding and helpers for the CCD colour-blob tracker.
package ccd_track_pkg;

  localparam int COORD_W = 11;
  localparam int COUNT_W = 19;
  localparam logic [COORD_W-1:0] COORD_MIN_INIT = 11'd2047;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  // Midpoint of two coordinates; the sum is carried one bit wider before the halving.
  function automatic logic [COORD_W-1:0] mid_point(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COORD_W:1];
  endfunction

  function automatic logic [COORD_W-1:0] span(input logic [COORD_W-1:0] lo,
                                              input logic [COORD_W-1:0] hi);
    return hi - lo + COORD_W'(1);
  endfunction

endpackage

// File: rtl/ccd_raster_counter.sv
// Raster position of the pixel currently on the bus; a clear restarts at (0,0) in the same cycle.
module ccd_raster_counter
  import ccd_track_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 512
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               advance_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               in_frame_o
);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  assign x_o        = clear_i ? '0 : x_q;
  assign y_o        = clear_i ? '0 : y_q;
  assign in_frame_o = (y_o < COORD_W'(V_ACTIVE));

  // Counting stops once past the last line so y cannot wrap back into the frame.
  always_comb begin
    x_d = x_o;
    y_d = y_o;
    if (advance_i && in_frame_o) begin
      if (x_o == COORD_W'(H_ACTIVE - 1)) begin
        x_d = '0;
        y_d = y_o + COORD_W'(1);
      end else begin
        x_d = x_o + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/ccd_blob_tracker.sv
// Per-frame colour-blob tracker: thresholds each pixel, accumulates a bounding box
// and match count, and publishes centre/size/count when the frame ends.
module ccd_blob_tracker
  import ccd_track_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 512,
  parameter int MIN_COUNT = 64
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [9:0]         iR,
  input  logic [9:0]         iG,
  input  logic [9:0]         iB,
  input  logic               iDVAL,
  input  logic               iFVAL,
  input  logic [9:0]         iR_MIN,
  input  logic [9:0]         iG_MAX,
  input  logic [9:0]         iB_MAX,
  output logic [COORD_W-1:0] oX_CENTER,
  output logic [COORD_W-1:0] oY_CENTER,
  output logic [COORD_W-1:0] oWIDTH,
  output logic [COORD_W-1:0] oHEIGHT,
  output logic [COUNT_W-1:0] oCOUNT,
  output logic               oFOUND,
  output logic               oDONE,
  output logic [31:0]        oHEX
);

  state_t             state_q, state_d;
  logic               fval_q;
  logic               fval_rise, fval_fall, start, resolve, found_now;
  logic               pix_vld, hit, match, in_frame;
  logic [COORD_W-1:0] x_cur, y_cur;
  logic [9:0]         r_min_q, g_max_q, b_max_q;
  logic [9:0]         r_min_eff, g_max_eff, b_max_eff;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COORD_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [COORD_W-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic [COORD_W-1:0] x_center_q, y_center_q, width_q, height_q;
  logic [COUNT_W-1:0] count_out_q;
  logic               found_q, done_q;

  assign fval_rise = iFVAL & ~fval_q;
  assign fval_fall = ~iFVAL & fval_q;
  assign start     = (state_q == IDLE) && fval_rise;
  assign resolve   = (state_q == RESOLVE);
  assign found_now = (count_q >= COUNT_W'(MIN_COUNT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fval_rise) state_d = ACCUM;
      ACCUM:   if (fval_fall) state_d = RESOLVE;
      RESOLVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // On the frame-start cycle the live thresholds are used directly so pixel (0,0) sees them.
  assign r_min_eff = start ? iR_MIN : r_min_q;
  assign g_max_eff = start ? iG_MAX : g_max_q;
  assign b_max_eff = start ? iB_MAX : b_max_q;
  assign match     = (iR >= r_min_eff) && (iG <= g_max_eff) && (iB <= b_max_eff);
  assign pix_vld   = (start || (state_q == ACCUM)) && iDVAL && iFVAL;
  assign hit       = pix_vld && in_frame && match;

  ccd_raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_raster (
    .clk_i      (iCLK),
    .rst_i      (iRST),
    .clear_i    (start),
    .advance_i  (pix_vld),
    .x_o        (x_cur),
    .y_o        (y_cur),
    .in_frame_o (in_frame)
  );

  always_comb begin
    count_d = start ? '0 : count_q;
    min_x_d = start ? COORD_MIN_INIT : min_x_q;
    min_y_d = start ? COORD_MIN_INIT : min_y_q;
    max_x_d = start ? '0 : max_x_q;
    max_y_d = start ? '0 : max_y_q;
    if (hit) begin
      count_d = count_d + COUNT_W'(1);
      if (x_cur < min_x_d) min_x_d = x_cur;
      if (y_cur < min_y_d) min_y_d = y_cur;
      if (x_cur > max_x_d) max_x_d = x_cur;
      if (y_cur > max_y_d) max_y_d = y_cur;
    end
  end

  // fval_q resets high so a frame already in progress at reset never looks like a new start.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      fval_q  <= 1'b1;
      r_min_q <= '0;
      g_max_q <= '0;
      b_max_q <= '0;
      count_q <= '0;
      min_x_q <= COORD_MIN_INIT;
      min_y_q <= COORD_MIN_INIT;
      max_x_q <= '0;
      max_y_q <= '0;
    end else begin
      state_q <= state_d;
      fval_q  <= iFVAL;
      if (start) begin
        r_min_q <= iR_MIN;
        g_max_q <= iG_MAX;
        b_max_q <= iB_MAX;
      end
      count_q <= count_d;
      min_x_q <= min_x_d;
      min_y_q <= min_y_d;
      max_x_q <= max_x_d;
      max_y_q <= max_y_d;
    end
  end

  // Centre and size only move on a found frame; count/found/done always update.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      x_center_q  <= '0;
      y_center_q  <= '0;
      width_q     <= '0;
      height_q    <= '0;
      count_out_q <= '0;
      found_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= resolve;
      if (resolve) begin
        count_out_q <= count_q;
        found_q     <= found_now;
        if (found_now) begin
          x_center_q <= mid_point(min_x_q, max_x_q);
          y_center_q <= mid_point(min_y_q, max_y_q);
          width_q    <= span(min_x_q, max_x_q);
          height_q   <= span(min_y_q, max_y_q);
        end
      end
    end
  end

  assign oX_CENTER = x_center_q;
  assign oY_CENTER = y_center_q;
  assign oWIDTH    = width_q;
  assign oHEIGHT   = height_q;
  assign oCOUNT    = count_out_q;
  assign oFOUND    = found_q;
  assign oDONE     = done_q;
  assign oHEX      = {1'b0, x_center_q, 1'b0, y_center_q, 8'h00};

endmodule

// File: tb/tb_ccd_blob_tracker.sv
// Directed table-driven bench for ccd_blob_tracker on an 8x4 raster.
module tb_ccd_blob_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  r, g, b, r_min, g_max, b_max;
  logic        dval, fval;
  logic [10:0] x_c, y_c, wid, hgt;
  logic [18:0] cnt;
  logic        found, done;
  logic [31:0] hex;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ccd_blob_tracker #(.H_ACTIVE(8), .V_ACTIVE(4), .MIN_COUNT(2)) dut (
    .iCLK(clk), .iRST(rst), .iR(r), .iG(g), .iB(b), .iDVAL(dval), .iFVAL(fval),
    .iR_MIN(r_min), .iG_MAX(g_max), .iB_MAX(b_max),
    .oX_CENTER(x_c), .oY_CENTER(y_c), .oWIDTH(wid), .oHEIGHT(hgt),
    .oCOUNT(cnt), .oFOUND(found), .oDONE(done), .oHEX(hex)
  );

  typedef struct {
    logic [31:0] mask;
    int          npix;
    bit          all_hit;
    bit          same;
    logic [9:0]  rval;
    logic [9:0]  rmin;
    int          chg_at;
    logic [9:0]  chg_val;
    int          e_cnt;
    bit          e_found;
    int          e_x, e_y, e_w, e_h;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_pixel(input bit hitp, input logic [9:0] rv, input int i);
    if (hitp) begin
      r = rv; g = 10'd0; b = 10'd0;
    end else begin
      r = 10'd1023;
      g = (i % 2 == 1) ? 10'd200 : 10'd0;
      b = (i % 2 == 1) ? 10'd0 : 10'd200;
    end
  endtask

  task automatic check_results(input string tag, input vec_t v);
    logic [10:0] ex, ey;
    ex = 11'(v.e_x);
    ey = 11'(v.e_y);
    chk({tag, " count"},  32'(cnt), 32'(v.e_cnt));
    chk({tag, " found"},  32'(found), 32'(v.e_found));
    chk({tag, " x"},      32'(x_c), 32'(v.e_x));
    chk({tag, " y"},      32'(y_c), 32'(v.e_y));
    chk({tag, " width"},  32'(wid), 32'(v.e_w));
    chk({tag, " height"}, 32'(hgt), 32'(v.e_h));
    chk({tag, " hex"},    hex, {1'b0, ex, 1'b0, ey, 8'h00});
  endtask

  task automatic run_frame(input string tag, input vec_t v);
    @(negedge clk);
    fval = 1'b0; dval = 1'b0;
    r_min = v.rmin; g_max = 10'd100; b_max = 10'd100;
    @(negedge clk);
    fval = 1'b1;
    if (!v.same) begin
      dval = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < v.npix; i++) begin
      if (i > 0 && i % 8 == 0) begin
        dval = 1'b0;
        @(negedge clk);
      end
      if (i == v.chg_at) r_min = v.chg_val;
      drive_pixel(v.all_hit || (i < 32 && v.mask[i]), v.rval, i);
      dval = 1'b1;
      @(negedge clk);
    end
    dval = 1'b0; fval = 1'b0;
    @(negedge clk);
    chk({tag, " done t+1"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({tag, " done t+2"}, 32'(done), 32'd1);
    check_results(tag, v);
    @(negedge clk);
    chk({tag, " done t+3"}, 32'(done), 32'd0);
  endtask

  initial begin
    vec_t post;
    vecs[0] = '{32'h0800_2400, 32, 0, 0, 10'd1023, 10'd512, -1, 10'd0, 3, 1, 3, 2, 4, 3};
    vecs[1] = '{32'h0000_0080, 32, 0, 0, 10'd1023, 10'd512, -1, 10'd0, 1, 0, 3, 2, 4, 3};
    vecs[2] = '{32'h0000_0003, 32, 0, 0, 10'd700,  10'd512,  1, 10'd1023, 2, 1, 0, 0, 2, 1};
    vecs[3] = '{32'h0000_0003, 32, 0, 0, 10'd700,  10'd1023, -1, 10'd0, 0, 0, 0, 0, 2, 1};
    vecs[4] = '{32'h0000_0000, 40, 1, 0, 10'd1023, 10'd512, -1, 10'd0, 32, 1, 3, 1, 8, 4};
    vecs[5] = '{32'h4000_0040, 32, 0, 0, 10'd1023, 10'd512, -1, 10'd0, 2, 1, 6, 1, 1, 4};
    vecs[6] = '{32'h0000_0003, 2,  0, 1, 10'd1023, 10'd512, -1, 10'd0, 2, 1, 0, 0, 2, 1};

    rst = 1'b1; fval = 1'b0; dval = 1'b0;
    r = '0; g = '0; b = '0; r_min = 10'd512; g_max = 10'd100; b_max = 10'd100;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    post = '{32'h0, 0, 0, 0, 10'd0, 10'd0, -1, 10'd0, 0, 0, 0, 0, 0, 0};
    check_results("reset", post);
    chk("reset done", 32'(done), 32'd0);

    for (int k = 0; k < 7; k++) run_frame($sformatf("vec%0d", k), vecs[k]);

    // Reset in the middle of a frame: that frame must never resolve.
    @(negedge clk);
    fval = 1'b1; dval = 1'b0;
    @(negedge clk);
    drive_pixel(1'b1, 10'd1023, 0); dval = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    post = '{32'h0, 0, 0, 0, 10'd0, 10'd0, -1, 10'd0, 0, 0, 0, 0, 0, 0};
    check_results("midrst", post);
    chk("midrst done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    dval = 1'b0; fval = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("midrst no done %0d", k), 32'(done), 32'd0);
    end
    chk("midrst count held", 32'(cnt), 32'd0);

    post = '{32'h0800_2400, 32, 0, 0, 10'd1023, 10'd512, -1, 10'd0, 3, 1, 3, 2, 4, 3};
    run_frame("postrst", post);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ccd_blob_tracker.md
# ccd_blob_tracker

Per-frame colour-blob tracker that sits directly downstream of the vertical-mirror stage, on the `CCD_PIXCLK` domain alongside the SDRAM write port. It consumes the mirrored RGB pixel stream and classifies each pixel against programmable colour thresholds. It accumulates a bounding box of matching pixels and, at end of frame, publishes the box centre (position), width/height (scale) and match count. A packed word is provided for the 8-digit hex display.

## Interface
Parameters:
- `H_ACTIVE`, 640: pixels per line.
- `V_ACTIVE`, 512: lines per frame.
- `MIN_COUNT`, 64: minimum matching pixels for a frame to count as "found".

Ports:
- `iCLK` in 1: pixel clock (`CCD_PIXCLK`). One clock; reset is synchronous and active-high.
- `iRST` in 1: synchronous, active-high reset.
- `iR`, `iG`, `iB` in 10 each: mirrored pixel colour.
- `iDVAL` in 1: pixel valid.
- `iFVAL` in 1: registered frame-valid level from the sensor.
- `iR_MIN`, `iG_MAX`, `iB_MAX` in 10 each: colour thresholds.
- `oX_CENTER`, `oY_CENTER` out 11 each: bounding-box centre.
- `oWIDTH`, `oHEIGHT` out 11 each: bounding-box size.
- `oCOUNT` out 19: matching pixels in the last frame.
- `oFOUND` out 1: last frame had `oCOUNT >= MIN_COUNT`.
- `oDONE` out 1: one-cycle pulse when results update.
- `oHEX` out 32: packed word `{1'b0,oX_CENTER,1'b0,oY_CENTER[10:0],8'h00}` for the 7-segment display.

## Operation
- **States:** IDLE, ACCUM, RESOLVE.
  - IDLE → ACCUM on an `iFVAL` rising edge (`iFVAL=1`, previous sample 0).
  - ACCUM → RESOLVE on an `iFVAL` falling edge.
  - RESOLVE → IDLE unconditionally after 1 cycle.
- **Frame start (rising-edge cycle):**
  - Latch the three thresholds into shadow registers; mid-frame threshold changes take effect next frame.
  - Clear the raster counters x and y to 0.
  - Set count=0, min_x=min_y=2047, max_x=max_y=0.
  - If `iDVAL=1` in this same cycle, the pixel is processed as pixel (0,0), and the accumulators load that pixel's contribution.
- **Pixel processing:**
  - A pixel is processed only when in ACCUM (or on the rising-edge cycle) with `iDVAL=1` and `iFVAL=1`.
  - Match: `R >= r_min && G <= g_max && B <= b_max`, all unsigned, using the shadowed thresholds.
  - On a match: count += 1; min/max x/y are updated with the current (x,y).
  - After each processed pixel, x increments. At x=`H_ACTIVE-1`, x wraps to 0 and y increments.
  - Pixels with y >= `V_ACTIVE` are ignored, so count never exceeds `H_ACTIVE*V_ACTIVE` and cannot overflow 19 bits.
- **RESOLVE:**
  - `oCOUNT` ← count and `oFOUND` ← (count >= `MIN_COUNT`), always.
  - If found: `oX_CENTER` = (min_x+max_x)>>1, `oY_CENTER` = (min_y+max_y)>>1, `oWIDTH` = max_x-min_x+1, `oHEIGHT` = max_y-min_y+1. Sums use 12 bits before the shift.
  - If not found: centre and size outputs hold their previous values.
  - `oDONE` is set for one cycle in all cases.
- **Falling edge while IDLE:** ignored.
- **Reset:**
  - All state returns to IDLE and all outputs go to 0.
  - If reset occurs mid-frame, that frame is discarded. No RESOLVE happens until a full rising-to-falling `iFVAL` frame has been seen.

## Timing
- `iFVAL` is sampled every cycle into a previous-sample register; edges are detected combinationally against it.
- Falling edge detected at cycle t → RESOLVE at t+1 → new outputs visible and `oDONE=1` at t+2 → `oDONE=0` at t+3.
- The accumulate path is single-cycle: the compare and the min/max/count update complete in the same cycle as `iDVAL`. There are no stalls and no backpressure.
- All outputs are registered; `oHEX` is combinational from registered outputs.
- Reset value of every output is 0.

## Structure
- **Package `ccd_track_pkg`:** coordinate width (11), count width (19), the `state_t` enum (IDLE, ACCUM, RESOLVE), and the min/max reset constant 2047.
- **Sub-module `ccd_raster_counter`:**
  - Inputs: clear, advance, `H_ACTIVE`.
  - Outputs: x, y, in_frame (y < `V_ACTIVE`).
- The tracker instantiates `ccd_raster_counter` and owns the FSM, the thresholds, the accumulators and the output registers.

## Test plan
All scenarios use `H_ACTIVE=8`, `V_ACTIVE=4`, `MIN_COUNT=2`.
- **Single blob:** matching pixels at (2,1), (5,1), (3,3); all others black → `oCOUNT=3`, `oX_CENTER=3`, `oY_CENTER=2`, `oWIDTH=4`, `oHEIGHT=3`, `oFOUND=1`, and `oDONE` exactly 2 cycles after `iFVAL` falls.
- **Below minimum:** after the single-blob frame, a frame with 1 match at (7,0) → `oCOUNT=1`, `oFOUND=0`, centre and size still 3/2/4/3.
- **Threshold shadowing:** `iR_MIN` changes mid-frame from 512 to 1023 → the current frame still uses 512; the next frame uses 1023.
- **Overflow guard:** 40 `iDVAL` pulses, all matching → `oCOUNT=32`, `oX_CENTER=3`, `oY_CENTER=1`, `oWIDTH=8`, `oHEIGHT=4`.
- **Reset mid-frame:** `iRST` asserted with `iFVAL=1` → all outputs 0, state IDLE, and no `oDONE` at that frame's `iFVAL` fall. The next full frame resolves normally.
- **Same-cycle start:** `iDVAL=1` with a matching pixel on the `iFVAL` rising-edge cycle, plus one more match at (1,0) → `oCOUNT=2`, min_x=0.
